// File: rtl/conv_stream_feeder.sv
// Host-loaded x/f vector buffers streamed out over two independent valid/ready
// master channels. Used as the stimulus source in front of conv_128_32.
module conv_stream_feeder #(
  parameter int WIDTH = 8,
  parameter int NX    = 128,
  parameter int LOGX  = 7,
  parameter int NF    = 32,
  parameter int LOGF  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [LOGX-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m_data_out_x,
  output logic             m_valid_x,
  input  logic             m_ready_x,
  output logic [WIDTH-1:0] m_data_out_f,
  output logic             m_valid_f,
  input  logic             m_ready_f
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FIN
  } state_e;

  localparam logic [LOGX-1:0] LAST_X = LOGX'(NX - 1);
  localparam logic [LOGF-1:0] LAST_F = LOGF'(NF - 1);
  localparam logic [LOGX:0]   NF_LIM = (LOGX + 1)'(NF);

  logic [WIDTH-1:0] mem_x [NX];
  logic [WIDTH-1:0] mem_f [NF];

  state_e          state_q,   state_d;
  logic [LOGX-1:0] cnt_x_q,   cnt_x_d;
  logic [LOGF-1:0] cnt_f_q,   cnt_f_d;
  logic            valid_x_q, valid_x_d;
  logic            valid_f_q, valid_f_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;

  logic wr_x, wr_f;

  // Buffers accept host writes only while no transmission is running.
  always_comb begin
    wr_x = wr_en && !busy_q && !wr_sel;
    wr_f = wr_en && !busy_q && wr_sel && ({1'b0, wr_addr} < NF_LIM);
  end

  always_ff @(posedge clk) begin
    if (wr_x) mem_x[wr_addr] <= wr_data;
    if (wr_f) mem_f[wr_addr[LOGF-1:0]] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    cnt_x_d   = cnt_x_q;
    cnt_f_d   = cnt_f_q;
    valid_x_d = valid_x_q;
    valid_f_d = valid_f_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEND;
          busy_d    = 1'b1;
          valid_x_d = 1'b1;
          valid_f_d = 1'b1;
          cnt_x_d   = '0;
          cnt_f_d   = '0;
        end
      end
      ST_SEND: begin
        // Counters park on the last index instead of wrapping; valid is what ends the channel.
        if (valid_x_q && m_ready_x) begin
          if (cnt_x_q == LAST_X) valid_x_d = 1'b0;
          else                   cnt_x_d   = cnt_x_q + 1'b1;
        end
        if (valid_f_q && m_ready_f) begin
          if (cnt_f_q == LAST_F) valid_f_d = 1'b0;
          else                   cnt_f_d   = cnt_f_q + 1'b1;
        end
        if (!valid_x_d && !valid_f_d) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_x_q   <= '0;
      cnt_f_q   <= '0;
      valid_x_q <= 1'b0;
      valid_f_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_x_q   <= cnt_x_d;
      cnt_f_q   <= cnt_f_d;
      valid_x_q <= valid_x_d;
      valid_f_q <= valid_f_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    busy         = busy_q;
    done         = done_q;
    m_valid_x    = valid_x_q;
    m_valid_f    = valid_f_q;
    m_data_out_x = mem_x[cnt_x_q];
    m_data_out_f = mem_f[cnt_f_q];
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder: directed steps with random
// ready patterns, checked every cycle against a vector/index reference model.
module tb_conv_stream_feeder;

  localparam int WIDTH = 8;
  localparam int NX    = 128;
  localparam int LOGX  = 7;
  localparam int NF    = 32;
  localparam int LOGF  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             wr_sel = 1'b0;
  logic [LOGX-1:0]  wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic             rdy_x = 1'b0;
  logic             rdy_f = 1'b0;
  logic             busy, done;
  logic [WIDTH-1:0] dx, df;
  logic             vx, vf;

  conv_stream_feeder #(
    .WIDTH(WIDTH), .NX(NX), .LOGX(LOGX), .NF(NF), .LOGF(LOGF)
  ) dut (
    .clk(clk), .reset(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .m_data_out_x(dx), .m_valid_x(vx), .m_ready_x(rdy_x),
    .m_data_out_f(df), .m_valid_f(vf), .m_ready_f(rdy_f)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: buffer images, run/finish flags, next expected index per channel.
  logic [WIDTH-1:0] mx [NX];
  logic [WIDTH-1:0] mf [NF];
  bit   mdl_busy = 1'b0;
  bit   mdl_fin  = 1'b0;
  int   ix = 0;
  int   jf = 0;

  int done_cnt, done_cyc, start_cyc, last_xfer_cyc, nx_seen, nf_seen;
  logic [WIDTH-1:0] last_x5;
  bit   pv_x, pr_x, pv_f, pr_f, p_rst;
  logic [WIDTH-1:0] pd_x, pd_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, then clock.
  task automatic tick();
    bit exp_vx, exp_vf;
    exp_vx = mdl_busy && (ix < NX);
    exp_vf = mdl_busy && (jf < NF);
    chk("busy", {31'd0, busy}, {31'd0, mdl_busy});
    chk("done", {31'd0, done}, {31'd0, mdl_fin});
    chk("valid_x", {31'd0, vx}, {31'd0, exp_vx});
    chk("valid_f", {31'd0, vf}, {31'd0, exp_vf});
    if (exp_vx) chk("data_x", {24'd0, dx}, {24'd0, mx[ix]});
    if (exp_vf) chk("data_f", {24'd0, df}, {24'd0, mf[jf]});
    if (pv_x && !pr_x && !p_rst) begin
      chk("hold_vx", {31'd0, vx}, 32'd1);
      chk("hold_dx", {24'd0, dx}, {24'd0, pd_x});
    end
    if (pv_f && !pr_f && !p_rst) begin
      chk("hold_vf", {31'd0, vf}, 32'd1);
      chk("hold_df", {24'd0, df}, {24'd0, pd_f});
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst && vx === 1'b1 && rdy_x) begin
      nx_seen++;
      last_xfer_cyc = cyc;
      if (exp_vx && ix == 5) last_x5 = dx;
    end
    if (!rst && vf === 1'b1 && rdy_f) begin
      nf_seen++;
      last_xfer_cyc = cyc;
    end
    pv_x = (vx === 1'b1); pr_x = rdy_x; pd_x = dx;
    pv_f = (vf === 1'b1); pr_f = rdy_f; pd_f = df;
    p_rst = rst;

    if (rst) begin
      mdl_busy = 1'b0;
      mdl_fin  = 1'b0;
    end else begin
      if (wr_en && !mdl_busy) begin
        if (!wr_sel) mx[int'(wr_addr)] = wr_data;
        else if (int'(wr_addr) < NF) mf[int'(wr_addr)] = wr_data;
      end
      if (mdl_busy) begin
        if (ix < NX && rdy_x) ix++;
        if (jf < NF && rdy_f) jf++;
        if (ix == NX && jf == NF) begin
          mdl_busy = 1'b0;
          mdl_fin  = 1'b1;
        end
      end else if (mdl_fin) begin
        mdl_fin = 1'b0;
      end else if (start) begin
        mdl_busy = 1'b1;
        ix = 0;
        jf = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = LOGX'(addr); wr_data = WIDTH'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_stats();
    done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1; nx_seen = 0; nf_seen = 0;
  endtask

  // mode 0: both ready; 1: random 50% each; 2: f stalled for the first 200 cycles
  task automatic run(input int mode, input int budget, input bit stop_at_fin);
    int n = 0;
    while ((mdl_busy || (mdl_fin && !stop_at_fin)) && n < budget) begin
      case (mode)
        1:       begin rdy_x = 1'($urandom_range(0, 1)); rdy_f = 1'($urandom_range(0, 1)); end
        2:       begin rdy_x = 1'b1; rdy_f = (n >= 200); end
        default: begin rdy_x = 1'b1; rdy_f = 1'b1; end
      endcase
      tick();
      n++;
    end
    chk("run_bound", {31'd0, (n < budget)}, 32'd1);
    rdy_x = 1'b0;
    rdy_f = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();

    // 1: ramp data, both ready, done latency
    for (int i = 0; i < NX; i++) wr(1'b0, i, i - 64);
    for (int j = 0; j < NF; j++) wr(1'b1, j, j - 16);
    wr(1'b1, NF + 3, 8'h55);
    clear_stats();
    do_start();
    run(0, 400, 1'b0);
    chk("t1_done_lat", 32'(done_cyc - start_cyc), 32'd129);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_nx", 32'(nx_seen), 32'(NX));
    chk("t1_nf", 32'(nf_seen), 32'(NF));
    tick();

    // 2: random back-pressure on both channels
    clear_stats();
    do_start();
    run(1, 3000, 1'b0);
    chk("t2_nx", 32'(nx_seen), 32'(NX));
    chk("t2_nf", 32'(nf_seen), 32'(NF));
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));

    // 3: f channel stalled long, x runs through alone
    clear_stats();
    do_start();
    run(2, 600, 1'b0);
    chk("t3_nx", 32'(nx_seen), 32'(NX));
    chk("t3_nf", 32'(nf_seen), 32'(NF));
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));

    // 4: write and restart attempts mid-stream are ignored
    clear_stats();
    do_start();
    rdy_x = 1'b1; rdy_f = 1'b1;
    repeat (3) tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd5; wr_data = 8'h7F; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run(0, 400, 1'b0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_nx", 32'(nx_seen), 32'(NX));
    do_start();
    run(0, 400, 1'b0);
    chk("t4_old_x5", {24'd0, last_x5}, 32'h0000_00C5);
    wr(1'b0, 5, 8'h7F);
    do_start();
    run(1, 3000, 1'b0);
    chk("t4_new_x5", {24'd0, last_x5}, 32'h0000_007F);

    // 5: reset in the middle of a transmission
    clear_stats();
    do_start();
    rdy_x = 1'b1; rdy_f = 1'b1;
    for (int n = 0; n < 200 && nx_seen < 40; n++) tick();
    chk("t5_reach40", 32'(nx_seen), 32'd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_vx_after_rst", {31'd0, vx}, 32'd0);
    chk("t5_vf_after_rst", {31'd0, vf}, 32'd0);
    tick();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    clear_stats();
    do_start();
    run(1, 3000, 1'b0);
    chk("t5_nx", 32'(nx_seen), 32'(NX));
    chk("t5_nf", 32'(nf_seen), 32'(NF));

    // 6: start during FIN ignored, start in the next IDLE cycle accepted
    clear_stats();
    do_start();
    run(0, 400, 1'b1);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    run(0, 400, 1'b0);
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    chk("t6_nx", 32'(nx_seen), 32'(2 * NX));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
